// File: rtl/mult_pkg.sv
// Shared types and defaults for slice_mux_seq: FSM state enum, default
// widths and the select-width helper.
package mult_pkg;

  localparam int W_DEF = 4;
  localparam int N_DEF = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Select fields are never narrower than one bit, even for N = 2.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_mux_seq_if.sv
// Handshake bundle for slice_mux_seq: input request side and output stream
// side, with master (driver) and slave (DUT) modports.
interface slice_mux_seq_if #(
  parameter int W = mult_pkg::W_DEF,
  parameter int N = mult_pkg::N_DEF
);

  localparam int SELW = mult_pkg::sel_width(N);

  logic [N*W-1:0]  in_data;
  logic [SELW-1:0] sel;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_idx;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  modport master (
    output in_data, sel, start, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_last, out_valid, busy
  );

  modport slave (
    input  in_data, sel, start, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_last, out_valid, busy
  );

endinterface

// File: rtl/slice_sel.sv
// Combinational slice extractor: returns slice i_idx of i_data, or zero when
// the index is beyond the last slice.
module slice_sel #(
  parameter int W    = 4,
  parameter int N    = 2,
  parameter int SELW = 1
) (
  input  logic [N*W-1:0]  i_data,
  input  logic [SELW-1:0] i_idx,
  output logic [W-1:0]    o_slice
);

  always_comb begin
    o_slice = '0;
    for (int k = 0; k < N; k++) begin
      if (i_idx == SELW'(k)) o_slice = i_data[k*W +: W];
    end
  end

endmodule

// File: rtl/slice_mux_seq.sv
// Registered slice multiplexer with optional auto-streaming of all slices.
// Define SLICE_MUX_SEQ_AUTO_EN to build the STREAM state, holding register and counter.
module slice_mux_seq
  import mult_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input logic            clk,
  input logic            rst_n,
  slice_mux_seq_if.slave bus
);

  localparam int SELW = sel_width(N);

  logic [SELW-1:0] w_idx;
  logic [N*W-1:0]  w_src;
  logic [W-1:0]    w_slice;
  logic            w_in_ready;
  logic            w_in_xfer;
  logic            w_out_xfer;

  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_idx;
  logic            r_out_last;
  logic            r_out_valid;

  slice_sel #(.W(W), .N(N), .SELW(SELW)) u_slice_sel (
    .i_data  (w_src),
    .i_idx   (w_idx),
    .o_slice (w_slice)
  );

  assign w_in_xfer  = bus.in_valid & w_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_last  = r_out_last;
  assign bus.out_valid = r_out_valid;

`ifdef SLICE_MUX_SEQ_AUTO_EN

  state_t          r_state;
  logic [N*W-1:0]  r_hold;
  logic [SELW-1:0] r_cnt;
  logic            r_busy;

  // While streaming, the extractor looks one slice ahead so a transfer can
  // load the next slice without a bubble.
  assign w_in_ready = (r_state == IDLE) & (!r_out_valid | bus.out_ready);
  assign w_src      = (r_state == STREAM) ? r_hold : bus.in_data;
  assign w_idx      = (r_state == STREAM)            ? r_cnt + SELW'(1) :
                      (w_in_xfer && bus.start)       ? '0 : bus.sel;
  assign bus.busy   = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            r_out_data  <= w_slice;
            r_out_idx   <= w_idx;
            r_out_valid <= 1'b1;
            r_out_last  <= !bus.start;
            if (bus.start) begin
              r_hold  <= bus.in_data;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= STREAM;
            end
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
          end
        end
        STREAM: begin
          if (w_out_xfer) begin
            if (r_cnt == SELW'(N-1)) begin
              r_state     <= IDLE;
              r_busy      <= 1'b0;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_cnt      <= w_idx;
              r_out_data <= w_slice;
              r_out_idx  <= w_idx;
              r_out_last <= (w_idx == SELW'(N-1));
            end
          end
        end
      endcase
    end
  end

`else

  assign w_in_ready = !r_out_valid | bus.out_ready;
  assign w_src      = bus.in_data;
  assign w_idx      = bus.sel;
  assign bus.busy   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_out_data  <= w_slice;
      r_out_idx   <= w_idx;
      r_out_last  <= 1'b1;
      r_out_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_slice_mux_seq.sv
// Scoreboard bench for slice_mux_seq with three instances (N = 2, 3, 4).
// Stream scenarios are exercised when SLICE_MUX_SEQ_AUTO_EN is defined.
module tb_slice_mux_seq;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t q2[$];
  exp_t q3[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  slice_mux_seq_if #(.W(4), .N(2)) b2 ();
  slice_mux_seq_if #(.W(4), .N(3)) b3 ();
  slice_mux_seq_if #(.W(4), .N(4)) b4 ();

  slice_mux_seq #(.W(4), .N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  slice_mux_seq #(.W(4), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  slice_mux_seq #(.W(4), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  function automatic logic [3:0] slice_of(input logic [15:0] d, input int k, input int n);
    logic [15:0] t;
    t = d >> (4 * k);
    if (k >= n) return 4'h0;
    return t[3:0];
  endfunction

  // Scoreboards: outputs are popped before the same-edge input is pushed.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b2.out_valid && b2.out_ready) begin
        vectors++;
        if (q2.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL sb_n2 unexpected output data=%h idx=%h", b2.out_data, b2.out_idx);
        end else begin
          e = q2.pop_front();
          if (b2.out_data !== e.data || {1'b0, b2.out_idx} !== e.idx || b2.out_last !== e.last) begin
            miscompares++;
            $display("[TB] FAIL sb_n2 got d=%h i=%h l=%b want d=%h i=%h l=%b",
                     b2.out_data, b2.out_idx, b2.out_last, e.data, e.idx, e.last);
          end
        end
      end
      if (b2.in_valid && b2.in_ready) begin
        e.data = slice_of({8'h00, b2.in_data}, int'(b2.sel), 2);
        e.idx  = {1'b0, b2.sel};
        e.last = 1'b1;
        q2.push_back(e);
      end

      if (b3.out_valid && b3.out_ready) begin
        vectors++;
        if (q3.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL sb_n3 unexpected output data=%h idx=%h", b3.out_data, b3.out_idx);
        end else begin
          e = q3.pop_front();
          if (b3.out_data !== e.data || b3.out_idx !== e.idx || b3.out_last !== e.last) begin
            miscompares++;
            $display("[TB] FAIL sb_n3 got d=%h i=%h l=%b want d=%h i=%h l=%b",
                     b3.out_data, b3.out_idx, b3.out_last, e.data, e.idx, e.last);
          end
        end
      end
      if (b3.in_valid && b3.in_ready) begin
        e.data = slice_of({4'h0, b3.in_data}, int'(b3.sel), 3);
        e.idx  = b3.sel;
        e.last = 1'b1;
        q3.push_back(e);
      end

      if (b4.out_valid && b4.out_ready) begin
        vectors++;
        if (q4.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL sb_n4 unexpected output data=%h idx=%h", b4.out_data, b4.out_idx);
        end else begin
          e = q4.pop_front();
          if (b4.out_data !== e.data || b4.out_idx !== e.idx || b4.out_last !== e.last) begin
            miscompares++;
            $display("[TB] FAIL sb_n4 got d=%h i=%h l=%b want d=%h i=%h l=%b",
                     b4.out_data, b4.out_idx, b4.out_last, e.data, e.idx, e.last);
          end
        end
      end
      if (b4.in_valid && b4.in_ready) begin
`ifdef SLICE_MUX_SEQ_AUTO_EN
        if (b4.start) begin
          for (int k = 0; k < 4; k++) begin
            e.data = slice_of(b4.in_data, k, 4);
            e.idx  = 2'(k);
            e.last = (k == 3);
            q4.push_back(e);
          end
        end else begin
          e.data = slice_of(b4.in_data, int'(b4.sel), 4);
          e.idx  = b4.sel;
          e.last = 1'b1;
          q4.push_back(e);
        end
`else
        e.data = slice_of(b4.in_data, int'(b4.sel), 4);
        e.idx  = b4.sel;
        e.last = 1'b1;
        q4.push_back(e);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (q2.size() == 0 && q3.size() == 0 && q4.size() == 0) break;
      step();
    end
  endtask

  task automatic test_reset();
    step();
    vectors++;
    if ({b2.out_valid, b3.out_valid, b4.out_valid, b4.busy, b4.out_last} !== 5'b0 ||
        b4.out_data !== 4'h0 || b4.out_idx !== 2'd0 || b2.out_data !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got v=%b%b%b busy=%b last=%b d=%h want all zero",
               b2.out_valid, b3.out_valid, b4.out_valid, b4.busy, b4.out_last, b4.out_data);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if ({b2.in_ready, b3.in_ready, b4.in_ready} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready got %b%b%b want 111", b2.in_ready, b3.in_ready, b4.in_ready);
    end
  endtask

  task automatic test_manual();
    b2.in_data = 8'hA5; b2.sel = 1'b1; b2.in_valid = 1'b1; b2.out_ready = 1'b1;
    step();
    b2.in_valid = 1'b0;
    vectors++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== 4'hA || b2.out_idx !== 1'b1 || b2.out_last !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL manual_a5 got v=%b d=%h i=%h l=%b want v=1 d=a i=1 l=1",
               b2.out_valid, b2.out_data, b2.out_idx, b2.out_last);
    end
    step();
    vectors++;
    if (b2.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL valid_clear got %b want 0", b2.out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      b2.in_data = 8'($urandom);   b2.sel = 1'($urandom_range(0, 1)); b2.in_valid = 1'b1;
      b4.in_data = 16'($urandom);  b4.sel = 2'($urandom_range(0, 3)); b4.in_valid = 1'b1;
      b4.start = 1'b0; b4.out_ready = 1'b1;
      step();
    end
    b2.in_valid = 1'b0; b4.in_valid = 1'b0;
    wait_idle();
    vectors++;
    if (q2.size() != 0 || q4.size() != 0 || b2.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL manual_drain got pending=%0d/%0d want 0/0", q2.size(), q4.size());
    end
  endtask

  task automatic test_out_of_range();
    b3.in_data = 12'hABC; b3.sel = 2'd3; b3.in_valid = 1'b1; b3.out_ready = 1'b1;
    step();
    b3.sel = 2'd2;
    vectors++;
    if (b3.out_valid !== 1'b1 || b3.out_data !== 4'h0 || b3.out_idx !== 2'd3 || b3.out_last !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sel_oor got v=%b d=%h i=%h l=%b want v=1 d=0 i=3 l=1",
               b3.out_valid, b3.out_data, b3.out_idx, b3.out_last);
    end
    step();
    b3.in_valid = 1'b0;
    vectors++;
    if (b3.out_data !== 4'hA || b3.out_idx !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL sel_top got d=%h i=%h want d=a i=2", b3.out_data, b3.out_idx);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    b2.out_ready = 1'b0; b2.in_data = 8'h3C; b2.sel = 1'b0; b2.in_valid = 1'b1;
    vectors++;
    if (b2.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_first_ready got %b want 1", b2.in_ready);
    end
    step();
    b2.in_data = 8'h7E; b2.sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (b2.in_ready !== 1'b0 || b2.out_valid !== 1'b1 || b2.out_data !== 4'hC || b2.out_idx !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold got rdy=%b v=%b d=%h i=%h want rdy=0 v=1 d=c i=0",
                 b2.in_ready, b2.out_valid, b2.out_data, b2.out_idx);
      end
      step();
    end
    b2.out_ready = 1'b1;
    #1;
    vectors++;
    if (b2.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_release_ready got %b want 1", b2.in_ready);
    end
    step();
    b2.in_valid = 1'b0;
    vectors++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== 4'h7 || b2.out_idx !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_second got v=%b d=%h i=%h want v=1 d=7 i=1", b2.out_valid, b2.out_data, b2.out_idx);
    end
    wait_idle();
  endtask

`ifdef SLICE_MUX_SEQ_AUTO_EN
  task automatic test_auto_stream();
    logic [3:0] want [4];
    want[0] = 4'h4; want[1] = 4'h3; want[2] = 4'h2; want[3] = 4'h1;
    b4.in_data = 16'h1234; b4.start = 1'b1; b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    step();
    b4.in_valid = 1'b0; b4.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (b4.out_valid !== 1'b1 || b4.out_data !== want[k] || b4.out_idx !== 2'(k) ||
          b4.out_last !== (k == 3) || b4.busy !== 1'b1 || b4.in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL auto_slice%0d got v=%b d=%h i=%h l=%b busy=%b rdy=%b want v=1 d=%h i=%0d l=%b busy=1 rdy=0",
                 k, b4.out_valid, b4.out_data, b4.out_idx, b4.out_last, b4.busy, b4.in_ready, want[k], k, (k == 3));
      end
      step();
    end
    vectors++;
    if (b4.busy !== 1'b0 || b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL auto_end got busy=%b v=%b rdy=%b want 0 0 1", b4.busy, b4.out_valid, b4.in_ready);
    end
  endtask

  task automatic test_auto_backpressure();
    logic [5:0] prev;
    logic       stalled;
    logic       done;
    done = 1'b0;
    b4.in_data = 16'hBEEF; b4.start = 1'b1; b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    step();
    b4.in_data = 16'h0000; b4.sel = 2'd3;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i == 3) b4.in_data = 16'hFFFF;
      b4.out_ready = (i % 2 == 0);
      vectors++;
      if (b4.in_ready !== 1'b0 || b4.busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL auto_bp_busy got rdy=%b busy=%b want rdy=0 busy=1", b4.in_ready, b4.busy);
      end
      prev = {b4.out_data, b4.out_idx};
      stalled = !b4.out_ready;
      if (b4.out_last && b4.out_ready) begin
        b4.in_valid = 1'b0; b4.start = 1'b0; done = 1'b1;
      end
      step();
      if (stalled) begin
        vectors++;
        if ({b4.out_data, b4.out_idx} !== prev) begin
          miscompares++;
          $display("[TB] FAIL auto_bp_hold got %h want %h", {b4.out_data, b4.out_idx}, prev);
        end
      end
    end
    b4.in_valid = 1'b0; b4.start = 1'b0;
    vectors++;
    if (!done || b4.busy !== 1'b0 || q4.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL auto_bp_end got done=%b busy=%b pending=%0d want 1 0 0", done, b4.busy, q4.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
`ifdef SLICE_MUX_SEQ_AUTO_EN
    b4.in_data = 16'h1234; b4.start = 1'b1; b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    step();
    b4.in_valid = 1'b0; b4.start = 1'b0;
    step();
    vectors++;
    if (b4.out_idx !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL mid_pre got idx=%h want 1", b4.out_idx);
    end
`else
    b4.in_data = 16'h1234; b4.sel = 2'd1; b4.start = 1'b1; b4.in_valid = 1'b1; b4.out_ready = 1'b0;
    step();
    b4.in_valid = 1'b0; b4.start = 1'b0;
    vectors++;
    if (b4.out_valid !== 1'b1 || b4.out_last !== 1'b1 || b4.out_data !== 4'h3 || b4.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_ignored got v=%b l=%b d=%h busy=%b want 1 1 3 0",
               b4.out_valid, b4.out_last, b4.out_data, b4.busy);
    end
`endif
    #1 rst_n = 1'b0;
    #1;
    q4.delete();
    vectors++;
    if (b4.out_valid !== 1'b0 || b4.out_data !== 4'h0 || b4.out_idx !== 2'd0 ||
        b4.out_last !== 1'b0 || b4.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset got v=%b d=%h i=%h l=%b busy=%b want all zero",
               b4.out_valid, b4.out_data, b4.out_idx, b4.out_last, b4.busy);
    end
    step();
    rst_n = 1'b1;
    step();
    vectors++;
    if (b4.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_ready got %b want 1", b4.in_ready);
    end
`ifdef SLICE_MUX_SEQ_AUTO_EN
    b4.in_data = 16'h5678; b4.start = 1'b1; b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    step();
    b4.in_valid = 1'b0; b4.start = 1'b0;
    vectors++;
    if (b4.out_idx !== 2'd0 || b4.out_data !== 4'h8 || b4.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_restart got i=%h d=%h busy=%b want 0 8 1", b4.out_idx, b4.out_data, b4.busy);
    end
`endif
    b4.out_ready = 1'b1;
    wait_idle();
    vectors++;
    if (q4.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL mid_drain got pending=%0d want 0", q4.size());
    end
  endtask

  initial begin
    b2.in_data = '0; b2.sel = '0; b2.start = 1'b0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;
    b3.in_data = '0; b3.sel = '0; b3.start = 1'b0; b3.in_valid = 1'b0; b3.out_ready = 1'b0;
    b4.in_data = '0; b4.sel = '0; b4.start = 1'b0; b4.in_valid = 1'b0; b4.out_ready = 1'b0;
    $display("[TB] starting slice_mux_seq bench");
    test_reset();
    test_manual();
    test_out_of_range();
    test_backpressure();
`ifdef SLICE_MUX_SEQ_AUTO_EN
    test_auto_stream();
    test_auto_backpressure();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
